// File: rtl/lut_multiplier_seq_param.sv
// Purpose: iterative unsigned WIDTH x WIDTH -> 2*WIDTH multiplier using a table of multiples of A.
// Latency: accept edge E -> out_valid after E+(2^DIGIT-1)+WIDTH/DIGIT (E+WIDTH/DIGIT on table reuse).
// Backpressure: in_ready only in IDLE; result/out_valid held in DONE until out_ready.
//
// Ports:
//   clk_mul    - clock, all state changes on rising edge
//   resetn_mul - asynchronous reset, active HIGH despite the name (1 = in reset)
//   in_valid / in_ready / src_a / src_b - operand handshake (src_a is tabled, src_b is sliced)
//   out_valid / out_ready / result      - product handshake
//   busy       - high while building the table or accumulating
// Optional feature macro: LUT_MULT_TABLE_REUSE_EN -- keeps the table and stored A
// across operations and skips BUILD when the new multiplicand matches.
module lut_multiplier_seq_param #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic                 clk_mul,
    input  logic                 resetn_mul,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     src_a,
    input  logic [WIDTH-1:0]     src_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy
);

    localparam int DEPTH   = 1 << DIGIT;
    localparam int SLICES  = WIDTH / DIGIT;
    localparam int SLICE_W = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int ENTRY_W = WIDTH + DIGIT;
    localparam int PROD_W  = 2 * WIDTH;
    localparam int SH_W    = $clog2(PROD_W) + 1;

    generate
        if (DIGIT < 1 || DIGIT > 6 || (WIDTH % DIGIT) != 0) begin : g_param_check
            $error("lut_multiplier_seq_param: WIDTH must be a multiple of DIGIT and DIGIT in 1..6");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUILD = 2'd1,
        ST_ACCUM = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               state_q;
    state_t               state_d;

    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;          // shifted right one digit per ACCUM cycle
    logic [ENTRY_W-1:0]   table_q [DEPTH];
    logic [DIGIT-1:0]     build_idx_q;
    logic [SLICE_W-1:0]   slice_q;
    logic [PROD_W-1:0]    acc_q;
    logic [PROD_W-1:0]    result_q;
    logic                 out_valid_q;

    logic                 accept;
    logic                 reuse_hit;
    logic                 build_last;
    logic                 slice_last;
    logic [DIGIT-1:0]     digit_sel;
    logic [SH_W-1:0]      shamt;
    logic [PROD_W-1:0]    addend;
    logic [PROD_W-1:0]    acc_sum;

`ifdef LUT_MULT_TABLE_REUSE_EN
    logic                 table_valid_q;
    assign reuse_hit = table_valid_q && (src_a == a_q);
`else
    assign reuse_hit = 1'b0;
`endif

    assign accept     = in_valid && (state_q == ST_IDLE);
    assign build_last = (build_idx_q == DIGIT'(DEPTH - 1));
    assign slice_last = (slice_q == SLICE_W'(SLICES - 1));
    // b_q is pre-shifted, so the current slice is always its low digit.
    assign digit_sel  = b_q[DIGIT-1:0];
    assign shamt      = SH_W'(slice_q) * SH_W'(DIGIT);
    assign addend     = PROD_W'(table_q[digit_sel]) << shamt;
    assign acc_sum    = acc_q + addend;

    assign in_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q == ST_BUILD) || (state_q == ST_ACCUM);
    assign out_valid  = out_valid_q;
    assign result     = result_q;

    always_ff @(posedge clk_mul or posedge resetn_mul) begin
        if (resetn_mul) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept)     state_d = reuse_hit ? ST_ACCUM : ST_BUILD;
            ST_BUILD: if (build_last) state_d = ST_ACCUM;
            ST_ACCUM: if (slice_last) state_d = ST_DONE;
            ST_DONE:  if (out_ready)  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_mul or posedge resetn_mul) begin
        if (resetn_mul) begin
            a_q         <= '0;
            b_q         <= '0;
            build_idx_q <= '0;
            slice_q     <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                table_q[k] <= '0;
            end
`ifdef LUT_MULT_TABLE_REUSE_EN
            table_valid_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        a_q         <= src_a;
                        b_q         <= src_b;
                        acc_q       <= '0;
                        slice_q     <= '0;
                        build_idx_q <= DIGIT'(1);
`ifdef LUT_MULT_TABLE_REUSE_EN
                        // A rebuild overwrites entries progressively, so the
                        // table is untrusted until the build completes.
                        if (!reuse_hit) begin
                            table_valid_q <= 1'b0;
                        end
`endif
                    end
                end
                ST_BUILD: begin
                    // entry[0] stays zero; each entry is the previous plus A.
                    table_q[build_idx_q] <= table_q[build_idx_q - 1'b1] + ENTRY_W'(a_q);
                    build_idx_q          <= build_idx_q + 1'b1;
`ifdef LUT_MULT_TABLE_REUSE_EN
                    if (build_last) begin
                        table_valid_q <= 1'b1;
                    end
`endif
                end
                ST_ACCUM: begin
                    acc_q   <= acc_sum;
                    b_q     <= b_q >> DIGIT;
                    slice_q <= slice_q + 1'b1;
                    if (slice_last) begin
                        result_q    <= acc_sum;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lut_multiplier_seq_param.sv
// Purpose: directed self-checking bench for lut_multiplier_seq_param (32/4 and 8/2 builds).
// Latency: n/a (bench).
// Backpressure: exercises held results under out_ready=0.
module tb_lut_multiplier_seq_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // 32x32, DIGIT=4 instance
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] result;
    logic        busy;

    // 8x8, DIGIT=2 instance
    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [7:0]  src_a8 = '0;
    logic [7:0]  src_b8 = '0;
    logic        out_valid8;
    logic        out_ready8 = 1'b1;
    logic [15:0] result8;
    logic        busy8;

    int errors = 0;
    int checks = 0;

`ifdef LUT_MULT_TABLE_REUSE_EN
    localparam int REUSE_LAT = 8;
`else
    localparam int REUSE_LAT = 23;
`endif

    always #5 clk = ~clk;

    lut_multiplier_seq_param #(.WIDTH(32), .DIGIT(4)) dut (
        .clk_mul    (clk),
        .resetn_mul (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .src_a      (src_a),
        .src_b      (src_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .busy       (busy)
    );

    lut_multiplier_seq_param #(.WIDTH(8), .DIGIT(2)) dut8 (
        .clk_mul    (clk),
        .resetn_mul (rst),
        .in_valid   (in_valid8),
        .in_ready   (in_ready8),
        .src_a      (src_a8),
        .src_b      (src_b8),
        .out_valid  (out_valid8),
        .out_ready  (out_ready8),
        .result     (result8),
        .busy       (busy8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Caller is in IDLE, 1 time unit after a rising edge.
    task automatic run32(input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int lat, input string tag);
        int n;
        bit rdy_seen;
        src_a    = a;
        src_b    = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        src_a    = ~a;      // operands may change freely after acceptance
        src_b    = ~b;
        n        = 0;
        rdy_seen = 1'b0;
        while (!out_valid && n < 200) begin
            if (in_ready) rdy_seen = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        if (in_ready) rdy_seen = 1'b1;
        chk({tag, "_latency"}, 64'(n), 64'(lat));
        chk({tag, "_result"}, result, exp);
        chk({tag, "_in_ready_low"}, 64'(rdy_seen), 64'd0);
        if (out_ready) begin
            @(posedge clk); #1;
            chk({tag, "_handoff_valid"}, 64'(out_valid), 64'd0);
            chk({tag, "_handoff_ready"}, 64'(in_ready), 64'd1);
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input string tag);
        int n;
        src_a8    = a;
        src_b8    = b;
        in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd7);
        chk({tag, "_result"}, 64'(result8), 64'(a) * 64'(b));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;

        // Reset state
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_result", result, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: all-ones operands
        run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 23, "t1_ones");

        // 2: zero operands still take full latency
        run32(32'h1234_5678, 32'h0, 64'h0, 23, "t2_b_zero");
        run32(32'h0, 32'hDEAD_BEEF, 64'h0, 23, "t2_a_zero");

        // 3: held result under backpressure, new operands ignored
        out_ready = 1'b0;
        run32(32'd3, 32'd5, 64'd15, 23, "t3_3x5");
        src_a    = 32'd100;
        src_b    = 32'd100;
        in_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("t3_hold_valid", 64'(out_valid), 64'd1);
        chk("t3_hold_result", result, 64'd15);
        chk("t3_hold_in_ready", 64'(in_ready), 64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t3_handoff_valid", 64'(out_valid), 64'd0);
        chk("t3_idle_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        chk("t3_no_restart_busy", 64'(busy), 64'd0);

        // 4: reset in the middle of ACCUM
        src_a    = 32'd7;
        src_b    = 32'd9;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (18) @(posedge clk);
        #1;
        chk("t4_mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("t4_rst_valid", 64'(out_valid), 64'd0);
        chk("t4_rst_result", result, 64'd0);
        chk("t4_rst_in_ready", 64'(in_ready), 64'd1);
        chk("t4_rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run32(32'd6, 32'd7, 64'd42, 23, "t4_6x7");

        // 5: repeated multiplicand (reuse path when the feature is built in)
        run32(32'h0000_ABCD, 32'd2, 64'h1579A, 23, "t5_first");
        run32(32'h0000_ABCD, 32'd3, 64'h20367, REUSE_LAT, "t5_reuse");
        run32(32'h0000_0001, 32'd3, 64'd3, 23, "t5_rebuild");

        // 6: 8x8 DIGIT=2 corners plus a random sweep
        run8(8'hFF, 8'hFF, "t6_ones");
        run8(8'h00, 8'hA5, "t6_zero");
        run8(8'h80, 8'h02, "t6_msb");
        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run8(ra, rb, "t6_rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
